// File: rtl/ycbcr444_to_rgb888_pkg.sv
// ----------------------------------------------------------------------------
// ycbcr444_to_rgb888_pkg : BT.601 studio-range YCbCr->RGB constants and types
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ycbcr444_to_rgb888_pkg;

   localparam int COEF_FRAC_DEF = 10;
   localparam int Y_OFFSET_DEF  = 16;
   localparam int C_OFFSET_DEF  = 128;
   localparam int PROD_W        = 21;
   localparam int SUM_W         = 23;

   // Coefficients scaled by 2^10
   localparam logic signed [12:0] K_Y  = 13'sd1192;
   localparam logic signed [12:0] K_RV = 13'sd1634;
   localparam logic signed [12:0] K_GU = 13'sd401;
   localparam logic signed [12:0] K_GV = 13'sd833;
   localparam logic signed [12:0] K_BU = 13'sd2065;

   typedef logic [7:0] pix_t;

   function automatic logic signed [PROD_W-1:0] mul_coef(input logic signed [8:0]  a,
                                                         input logic signed [12:0] k);
      return PROD_W'(a) * PROD_W'(k);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_u8.sv
// ----------------------------------------------------------------------------
// sat_u8 : round-to-nearest, arithmetic shift and clamp to unsigned 8 bit
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_u8
   import ycbcr444_to_rgb888_pkg::*;
#(
   parameter int IN_W = 23,
   parameter int FRAC = 10
) (
   input  logic signed [IN_W-1:0] din,
   output pix_t                   dout
);

   localparam logic signed [IN_W-1:0] RND   = IN_W'(2 ** (FRAC - 1));
   localparam logic signed [IN_W-1:0] MAX_V = IN_W'(255);

   logic signed [IN_W-1:0] rounded;
   logic signed [IN_W-1:0] shifted;

   always_comb begin
      rounded = din + RND;
      shifted = rounded >>> FRAC;
      dout    = pix_t'(shifted);
      if (shifted < 0) begin
         dout = 8'h00;
      end else if (shifted > MAX_V) begin
         dout = 8'hFF;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ycbcr444_to_rgb888.sv
// ----------------------------------------------------------------------------
// ycbcr444_to_rgb888 : 3-stage BT.601 colour-space converter with sync delay
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ycbcr444_to_rgb888
   import ycbcr444_to_rgb888_pkg::*;
#(
   parameter int COEF_FRAC = COEF_FRAC_DEF,
   parameter int Y_OFFSET  = Y_OFFSET_DEF,
   parameter int C_OFFSET  = C_OFFSET_DEF,
   parameter int BLANK_RGB = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] y_i,
   input  logic [7:0] cb_i,
   input  logic [7:0] cr_i,
   input  logic       de_i,
   input  logic       hs_i,
   input  logic       vs_i,
   output logic [7:0] r_o,
   output logic [7:0] g_o,
   output logic [7:0] b_o,
   output logic       de_o,
   output logic       hs_o,
   output logic       vs_o
);

   logic signed [8:0]        yo, cbo, cro;
   logic signed [PROD_W-1:0] ky, krv, kgu, kgv, kbu;
   logic [2:0]               sync1, sync2;   // {vs, hs, de}
   logic signed [SUM_W-1:0]  sum [3];
   pix_t                     sat [3];

   always_comb begin
      sum[0] = SUM_W'(ky) + SUM_W'(krv);
      sum[1] = SUM_W'(ky) - SUM_W'(kgu) - SUM_W'(kgv);
      sum[2] = SUM_W'(ky) + SUM_W'(kbu);
   end

   generate
      for (genvar i = 0; i < 3; i++) begin : g_sat
         sat_u8 #(
            .IN_W (SUM_W),
            .FRAC (COEF_FRAC)
         ) u_sat (
            .din  (sum[i]),
            .dout (sat[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         yo    <= '0;
         cbo   <= '0;
         cro   <= '0;
         ky    <= '0;
         krv   <= '0;
         kgu   <= '0;
         kgv   <= '0;
         kbu   <= '0;
         sync1 <= '0;
         sync2 <= '0;
         r_o   <= '0;
         g_o   <= '0;
         b_o   <= '0;
         de_o  <= 1'b0;
         hs_o  <= 1'b0;
         vs_o  <= 1'b0;
      end else begin
         yo    <= $signed({1'b0, y_i})  - 9'(Y_OFFSET);
         cbo   <= $signed({1'b0, cb_i}) - 9'(C_OFFSET);
         cro   <= $signed({1'b0, cr_i}) - 9'(C_OFFSET);
         sync1 <= {vs_i, hs_i, de_i};

         ky    <= mul_coef(yo,  K_Y);
         krv   <= mul_coef(cro, K_RV);
         kgu   <= mul_coef(cbo, K_GU);
         kgv   <= mul_coef(cro, K_GV);
         kbu   <= mul_coef(cbo, K_BU);
         sync2 <= sync1;

         {vs_o, hs_o, de_o} <= sync2;
         // Syncs are never blanked; only the colour components are
         if ((BLANK_RGB != 0) && !sync2[0]) begin
            r_o <= '0;
            g_o <= '0;
            b_o <= '0;
         end else begin
            r_o <= sat[0];
            g_o <= sat[1];
            b_o <= sat[2];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ycbcr444_to_rgb888.sv
// ----------------------------------------------------------------------------
// tb_ycbcr444_to_rgb888 : directed + soak bench against a behavioural model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ycbcr444_to_rgb888;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] y_i = '0, cb_i = '0, cr_i = '0;
   logic       de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
   logic [7:0] r_o, g_o, b_o;
   logic       de_o, hs_o, vs_o;

   int tests = 0;
   int fails = 0;
   bit run   = 1'b0;

   typedef struct {
      bit         v;
      logic [7:0] y, cb, cr;
      logic       de, hs, vs;
   } samp_t;

   samp_t hist [3];

   ycbcr444_to_rgb888 dut (
      .clk  (clk),  .rst  (rst),
      .y_i  (y_i),  .cb_i (cb_i), .cr_i (cr_i),
      .de_i (de_i), .hs_i (hs_i), .vs_i (vs_i),
      .r_o  (r_o),  .g_o  (g_o),  .b_o  (b_o),
      .de_o (de_o), .hs_o (hs_o), .vs_o (vs_o)
   );

   always #5 clk = ~clk;

   function automatic int clamp8(input int v);
      if (v < 0)   return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   // floor((x + 512) / 1024) for BT.601 fixed-point, then clamp
   function automatic logic [23:0] model(input int y, input int cb, input int cr);
      int yy, u, v, r, g, b;
      yy = 1192 * (y - 16);
      u  = cb - 128;
      v  = cr - 128;
      r  = clamp8((yy + 1634 * v + 512) >>> 10);
      g  = clamp8((yy - 401 * u - 833 * v + 512) >>> 10);
      b  = clamp8((yy + 2065 * u + 512) >>> 10);
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pix(input int y, input int cb, input int cr,
                      input bit de, input bit hs, input bit vs);
      @(negedge clk);
      y_i  = y[7:0];
      cb_i = cb[7:0];
      cr_i = cr[7:0];
      de_i = de;
      hs_i = hs;
      vs_i = vs;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) hist[i].v = 1'b0;
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = '{1'b1, y_i, cb_i, cr_i, de_i, hs_i, vs_i};
      end
   end

   always @(negedge clk) begin
      logic [26:0] exp;
      if (run) begin
         exp = '0;
         if (!rst && hist[2].v) begin
            exp[26:3] = hist[2].de ? model(hist[2].y, hist[2].cb, hist[2].cr) : 24'h0;
            exp[2:0]  = {hist[2].de, hist[2].hs, hist[2].vs};
         end
         check("pipe", {5'b0, r_o, g_o, b_o, de_o, hs_o, vs_o}, {5'b0, exp});
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) hist[i].v = 1'b0;

      // Model pins
      check("model_black", model(16, 128, 128),  24'h000000);
      check("model_white", model(235, 128, 128), 24'hFFFFFF);
      check("model_over",  model(255, 128, 128), 24'hFFFFFF);
      check("model_red",   model(81, 90, 240),   24'hFE0000);

      repeat (2) @(negedge clk);
      check("reset_out", {r_o, g_o, b_o, 5'b0, de_o, hs_o, vs_o}, 32'h0);
      rst = 1'b0;
      run = 1'b1;

      pix(16, 128, 128, 1, 0, 0);
      repeat (3) @(posedge clk); #1;
      check("black", {r_o, g_o, b_o, 7'b0, de_o}, {24'h000000, 8'h01});

      pix(235, 128, 128, 1, 0, 0);
      repeat (3) @(posedge clk); #1;
      check("white", {r_o, g_o, b_o}, 24'hFFFFFF);

      pix(255, 128, 128, 1, 0, 0);
      repeat (3) @(posedge clk); #1;
      check("over_white", {r_o, g_o, b_o}, 24'hFFFFFF);

      pix(81, 90, 240, 1, 0, 0);
      repeat (3) @(posedge clk); #1;
      check("red", {r_o, g_o, b_o}, 24'hFE0000);

      pix(235, 128, 128, 0, 0, 1);
      repeat (3) @(posedge clk); #1;
      check("blank", {r_o, g_o, b_o, 5'b0, de_o, hs_o, vs_o}, {24'h0, 8'h01});

      // Single-cycle hs pulse
      pix(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      pix(0, 0, 0, 0, 1, 0);
      @(posedge clk); #1;
      check("hs_before", {31'b0, hs_o}, 32'h0);
      pix(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk); #1;
      check("hs_edge", {31'b0, hs_o}, 32'h1);
      @(posedge clk); #1;
      check("hs_fall", {31'b0, hs_o}, 32'h0);

      // 5-cycle de burst with random pixels
      for (int i = 0; i < 5; i++)
         pix($urandom_range(255), $urandom_range(255), $urandom_range(255), 1, 0, 0);
      pix(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("de_tail", {31'b0, de_o}, 32'h1);
      repeat (3) @(posedge clk); #1;
      check("de_off", {r_o, g_o, b_o, 7'b0, de_o}, 32'h0);

      // Reset asserted between edges during a white burst
      for (int i = 0; i < 5; i++) pix(235, 128, 128, 1, 1, 1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("async_rst", {r_o, g_o, b_o, 5'b0, de_o, hs_o, vs_o}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst1", {r_o, g_o, b_o, 7'b0, de_o}, 32'h0);
      @(posedge clk); #1;
      check("post_rst2", {r_o, g_o, b_o, 7'b0, de_o}, 32'h0);
      @(posedge clk); #1;
      check("post_rst3", {r_o, g_o, b_o, 7'b0, de_o}, {24'hFFFFFF, 8'h01});

      // Random soak
      for (int i = 0; i < 10000; i++)
         pix($urandom_range(255), $urandom_range(255), $urandom_range(255),
             ($urandom_range(7) != 0), ($urandom_range(31) == 0), ($urandom_range(63) == 0));
      pix(0, 0, 0, 0, 0, 0);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ycbcr444_to_rgb888.md
Name: ycbcr444_to_rgb888

Overview:
Colour-space converter that sits directly downstream of the YCbCr 4:2:2-to-4:4:4 upsampler.
- Takes per-pixel Y/Cb/Cr (BT.601 studio range) plus de/hs/vs.
- Produces 8-bit RGB with sync signals re-aligned to the pixel data.
- Fixed 3-stage pipeline, no backpressure; feeds the RGB display/encoder path.

Parameters:
COEF_FRAC, 10, fractional bits of fixed-point coefficients (values below are for 10).
Y_OFFSET, 16, black-level offset subtracted from Y.
C_OFFSET, 128, zero-level offset subtracted from Cb/Cr.
BLANK_RGB, 1, 1 = force r/g/b to 0 while delayed de is low; 0 = pass computed value.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
y_i  input  8  luma.
cb_i  input  8  blue chroma.
cr_i  input  8  red chroma.
de_i  input  1  data enable.
hs_i  input  1  horizontal sync.
vs_i  input  1  vertical sync.
r_o  output  8  red.
g_o  output  8  green.
b_o  output  8  blue.
de_o  output  1  de delayed 3 cycles.
hs_o  output  1  hs delayed 3 cycles.
vs_o  output  1  vs delayed 3 cycles.

Behaviour:
- Reset: one clock, asynchronous active-high reset; all pipeline registers and all outputs clear to 0 immediately on rst assertion, regardless of clk.
- Reset mid-frame: in-flight pixels are discarded. The first valid output appears 3 cycles after the first clk edge following rst deassertion with de_i=1.
- Latency: exactly 3 clk cycles from input sample to output, for data and syncs alike. No stall, and no dependence on de_i for the pipeline advancing.
- Stage 1: yo = y_i - Y_OFFSET; cbo = cb_i - C_OFFSET; cro = cr_i - C_OFFSET. Each is 9-bit signed. de/hs/vs delayed one stage.
- Stage 2: registered signed products:
  - ky = 1192*yo
  - krv = 1634*cro
  - kgu = 401*cbo
  - kgv = 833*cro
  - kbu = 2065*cbo
  - Each product is 21-bit signed. Syncs delayed a second stage.
- Stage 3:
  - sr = ky + krv; sg = ky - kgu - kgv; sb = ky + kbu (23-bit signed).
  - Add rounding constant 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - Clamp: result < 0 -> 0; result > 255 -> 255; else low 8 bits.
  - Register into r_o/g_o/b_o together with de_o/hs_o/vs_o.
- Blanking: if BLANK_RGB=1 and stage-3 de is 0, r_o/g_o/b_o = 0. hs_o/vs_o are never altered, only delayed.
- Inputs outside studio range (Y<16 or Y>235, C<16 or C>240) are legal and handled purely by clamping. No flag, no error.
- Back-to-back pixels every cycle are supported. Throughput is 1 pixel/clk.

Decomposition:
- Shared video package: coefficient constants (1192, 1634, 401, 833, 2065), Y_OFFSET/C_OFFSET defaults, and the 8-bit pixel component type.
- One natural sub-module, sat_u8: signed-in, round-shift and clamp to unsigned 8-bit. Instantiate it three times (R/G/B).
- The sync delay line stays inline; it is a 3-deep shift register.

Test Plan:
- Black: Y=16, Cb=128, Cr=128, de=1 -> 3 cycles later r,g,b = 0,0,0 and de_o=1.
- White/overrange: Y=235 then Y=255 (Cb=Cr=128) -> 255,255,255 both times; the Y=255 case exercises the upper clamp (raw 278).
- Red: Y=81, Cb=90, Cr=240 -> r=254, g=0, b=0; g and b exercise the lower clamp (raw -1).
- Sync alignment: single-cycle hs_i pulse and 5-cycle de_i burst with random pixels -> hs_o/de_o edges exactly 3 cycles later. With BLANK_RGB=1, rgb=0 on every cycle where de_o=0.
- Reset mid-line: assert rst asynchronously (between edges) during a de burst -> all outputs 0 within the same cycle. After release, no stale pixel appears, and the first output is valid 3 cycles after the first de_i=1 edge.
- Random soak: 10k random Y/Cb/Cr per clk vs. a reference model using the same integer formula -> bit-exact match at 3-cycle offset.
